// File: rtl/adder_nibble_seq.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit adder, least significant nibble first.
// Define ADDSEQ_SUB_EN to add the op_sub_i port and the two's-complement subtract mode.

module adder4bit_beh (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};

endmodule

module adder_nibble_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef ADDSEQ_SUB_EN
  input  logic             op_sub_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = $clog2(NIB);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef ADDSEQ_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic [CW+1:0]    shamt;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b_raw;
  logic [3:0]       nib_b;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic [WIDTH-1:0] nib_mask;
  logic [WIDTH-1:0] nib_ins;
  logic             is_last;

  assign shamt     = {cnt_q, 2'b00};
  assign nib_a     = 4'(a_q >> shamt);
  assign nib_b_raw = 4'(b_q >> shamt);
`ifdef ADDSEQ_SUB_EN
  assign nib_b     = sub_q ? ~nib_b_raw : nib_b_raw;
`else
  assign nib_b     = nib_b_raw;
`endif
  assign nib_mask  = WIDTH'(4'hF) << shamt;
  assign nib_ins   = WIDTH'(nib_sum) << shamt;
  assign is_last   = (cnt_q == CW'(NIB - 1));

  adder4bit_beh u_adder (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .cin_i  (carry_q),
    .sum_o  (nib_sum),
    .cout_o (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef ADDSEQ_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        if (start_i) begin
          // Nibble-0 carry-in is preloaded into the carry chain register.
          a_d     = a_i;
          b_d     = b_i;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
`ifdef ADDSEQ_SUB_EN
          sub_d   = op_sub_i;
          carry_d = op_sub_i ? 1'b1 : cin_i;
`else
          carry_d = cin_i;
`endif
        end
      end
      StRun: begin
        sum_d   = (sum_q & ~nib_mask) | nib_ins;
        carry_d = nib_cout;
        cnt_d   = cnt_q + CW'(1);
        if (is_last) begin
          cnt_d   = '0;
          cout_d  = nib_cout;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADDSEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ADDSEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_adder_nibble_seq.sv
// Scoreboard bench for adder_nibble_seq: a cycle-level protocol model predicts results and
// done timing; a negedge monitor compares whatever the DUT presents.

module tb_adder_nibble_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             cin_i = 1'b0;
  logic             op_sub = 1'b0;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;

  adder_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .cin_i    (cin_i),
`ifdef ADDSEQ_SUB_EN
    .op_sub_i (op_sub),
`endif
    .busy_o   (busy_o),
    .done_o   (done_o),
    .sum_o    (sum_o),
    .cout_o   (cout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    int               cyc;
  } exp_t;

  exp_t             sb_q[$];
  int               cyc = 0;
  int               rem = 0;
  bit               armed = 1'b0;
  logic [WIDTH-1:0] last_sum = '0;
  logic             last_cout = 1'b0;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: an operation, once accepted, occupies NIB cycles and then
  // presents its result; a new request is taken whenever nothing is in progress.
  always @(posedge clk_i) begin
    logic [WIDTH:0] r;
    cyc++;
    if (!rst_ni) begin
      sb_q.delete();
      rem       = 0;
      last_sum  = '0;
      last_cout = 1'b0;
      armed     = 1'b1;
    end else if (rem == 0 && start_i) begin
      r = (WIDTH + 1)'(a_i) + (WIDTH + 1)'(b_i) + (WIDTH + 1)'(cin_i);
`ifdef ADDSEQ_SUB_EN
      if (op_sub) begin
        r[WIDTH-1:0] = a_i - b_i;
        r[WIDTH]     = (a_i >= b_i);
      end
`endif
      sb_q.push_back('{sum: r[WIDTH-1:0], cout: r[WIDTH], cyc: cyc + NIB});
      rem = NIB;
    end else if (rem > 0) begin
      rem--;
    end
  end

  always @(negedge clk_i) begin
    exp_t e;
    logic exp_done;
    if (armed) begin
      exp_done = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
      check("done", {31'd0, done_o}, {31'd0, exp_done});
      check("busy", {31'd0, busy_o}, {31'd0, (rem > 0)});
      if (done_o && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sum", {16'd0, sum_o}, {16'd0, e.sum});
        check("cout", {31'd0, cout_o}, {31'd0, e.cout});
        last_sum  = e.sum;
        last_cout = e.cout;
      end else if (!done_o && rem == 0) begin
        check("sum_hold", {16'd0, sum_o}, {16'd0, last_sum});
        check("cout_hold", {31'd0, cout_o}, {31'd0, last_cout});
      end
      if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        check("done_missing", 32'd0, 32'd1);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (rem != 0 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (rem != 0) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic s);
    a_i     = a;
    b_i     = b;
    cin_i   = c;
    op_sub  = s;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                    input logic s);
    issue(a, b, c, s);
    wait_idle();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    op(16'h1234, 16'h4321, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op(16'h000F, 16'h0000, 1'b1, 1'b0);
    op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

    // Second request mid-operation must be dropped.
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk_i);
    a_i = 16'h7777; b_i = 16'h8888; cin_i = 1'b1; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_idle();
    @(negedge clk_i);

    // Held start: back-to-back operations from the done cycle.
    a_i = 16'hABCD; b_i = 16'h1357; cin_i = 1'b0; start_i = 1'b1;
    repeat (16) begin
      @(negedge clk_i);
      a_i = 16'($urandom);
      b_i = 16'($urandom);
    end
    start_i = 1'b0;
    wait_idle();
    @(negedge clk_i);

    // Reset in the middle of a run abandons the operation.
    issue(16'h5A5A, 16'hA5A5, 1'b1, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (NIB + 2) @(negedge clk_i);
    op(16'h8000, 16'h8000, 1'b0, 1'b0);

`ifdef ADDSEQ_SUB_EN
    op(16'h0005, 16'h0007, 1'b0, 1'b1);
    op(16'h0007, 16'h0005, 1'b1, 1'b1);
    op(16'h1234, 16'h1234, 1'b0, 1'b1);
`endif

    // Random traffic with random gaps and operand/start noise while busy.
    for (int i = 0; i < 60; i++) begin
      a_i     = 16'($urandom);
      b_i     = 16'($urandom);
      cin_i   = 1'($urandom);
`ifdef ADDSEQ_SUB_EN
      op_sub  = 1'($urandom);
`endif
      start_i = ($urandom_range(0, 3) != 0);
      @(negedge clk_i);
    end
    start_i = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk_i);
    if (sb_q.size() != 0) check("sb_drain", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
